// File: rtl/memdp_clr.sv
// Dual-port RAM with per-lane write enables and a hardware zero-fill sequence.
// Define MEMDP_OUTREG_EN to add a second read-data register stage per port.
module memdp_clr #(
    parameter int LW = 2,
    parameter int NL = 4,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    output logic             busy,
    input  logic             a_en,
    input  logic [NL-1:0]    a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [LW*NL-1:0] a_din,
    output logic [LW*NL-1:0] a_dout,
    output logic             a_vld,
    input  logic             b_en,
    input  logic [NL-1:0]    b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [LW*NL-1:0] b_din,
    output logic [LW*NL-1:0] b_dout,
    output logic             b_vld
);
    localparam int DW    = LW * NL;
    localparam int DEPTH = 2 ** AW;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] a_dout_q, b_dout_q;
    logic          a_vld_q, b_vld_q;
    logic          a_rd, b_rd;

    assign busy = (state_q == CLEAR);
    assign a_rd = a_en && !busy;
    assign b_rd = b_en && !busy;

    // clr_req is only looked at in IDLE, so a running clear never restarts or extends
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {AW{1'b1}}) begin
                state_d = IDLE;
            end
        end else if (clr_req) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Port A owns any lane it writes; port B only fills lanes A leaves alone on a shared address
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (a_en && a_we[i]) begin
                    mem[a_addr][i*LW +: LW] <= a_din[i*LW +: LW];
                end
                if (b_en && b_we[i] && !(a_en && a_we[i] && (a_addr == b_addr))) begin
                    mem[b_addr][i*LW +: LW] <= b_din[i*LW +: LW];
                end
            end
        end
    end

    // Reads sample the array before this cycle's writes land, giving read-first behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout_q <= '0;
            a_vld_q  <= 1'b0;
            b_dout_q <= '0;
            b_vld_q  <= 1'b0;
        end else begin
            a_vld_q <= a_rd;
            b_vld_q <= b_rd;
            if (a_rd) begin
                a_dout_q <= mem[a_addr];
            end
            if (b_rd) begin
                b_dout_q <= mem[b_addr];
            end
        end
    end

`ifdef MEMDP_OUTREG_EN
    logic [DW-1:0] a_dout2_q, b_dout2_q;
    logic          a_vld2_q, b_vld2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout2_q <= '0;
            a_vld2_q  <= 1'b0;
            b_dout2_q <= '0;
            b_vld2_q  <= 1'b0;
        end else begin
            a_vld2_q <= a_vld_q;
            b_vld2_q <= b_vld_q;
            if (a_vld_q) begin
                a_dout2_q <= a_dout_q;
            end
            if (b_vld_q) begin
                b_dout2_q <= b_dout_q;
            end
        end
    end

    assign a_dout = a_dout2_q;
    assign a_vld  = a_vld2_q;
    assign b_dout = b_dout2_q;
    assign b_vld  = b_vld2_q;
`else
    assign a_dout = a_dout_q;
    assign a_vld  = a_vld_q;
    assign b_dout = b_dout_q;
    assign b_vld  = b_vld_q;
`endif

endmodule

// File: tb/tb_memdp_clr.sv
// Randomized and directed bench for memdp_clr, checked every cycle against a behavioural model.
// Honours MEMDP_OUTREG_EN by expecting two cycles of read latency instead of one.
module tb_memdp_clr;
    localparam int LW    = 2;
    localparam int NL    = 4;
    localparam int AW    = 4;
    localparam int DW    = LW * NL;
    localparam int DEPTH = 2 ** AW;
`ifdef MEMDP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clrReq;
    logic          busy;
    logic          aEn, bEn;
    logic [NL-1:0] aWe, bWe;
    logic [AW-1:0] aAddr, bAddr;
    logic [DW-1:0] aDin, bDin, aDout, bDout;
    logic          aVld, bVld;

    int assertCount = 0;
    int failCount   = 0;

    memdp_clr #(.LW(LW), .NL(NL), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clrReq), .busy(busy),
        .a_en(aEn), .a_we(aWe), .a_addr(aAddr), .a_din(aDin), .a_dout(aDout), .a_vld(aVld),
        .b_en(bEn), .b_we(bWe), .b_addr(bAddr), .b_din(bDin), .b_dout(bDout), .b_vld(bVld)
    );

    always #5 clk = ~clk;

    // Behavioural model: array contents, remaining clear cycles, and a short read-result pipeline
    logic [DW-1:0] modelMem [DEPTH];
    int            clearLeft = DEPTH;
    logic [DW-1:0] pipeDoutA [2] = '{default: '0};
    logic [DW-1:0] pipeDoutB [2] = '{default: '0};
    logic          pipeVldA  [2] = '{default: 1'b0};
    logic          pipeVldB  [2] = '{default: 1'b0};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        clearLeft = DEPTH;
        for (int i = 0; i < 2; i++) begin
            pipeDoutA[i] = '0; pipeDoutB[i] = '0;
            pipeVldA[i]  = 1'b0; pipeVldB[i]  = 1'b0;
        end
    endtask

    always @(negedge rst_n) modelReset();

    always @(posedge clk) begin
        logic [DW-1:0] rdA, rdB, word;
        logic          vA, vB;
        if (!rst_n) begin
            modelReset();
        end else begin
            vA = 1'b0; vB = 1'b0; rdA = pipeDoutA[0]; rdB = pipeDoutB[0];
            if (clearLeft > 0) begin
                modelMem[DEPTH - clearLeft] = '0;
                clearLeft--;
            end else begin
                if (aEn) begin rdA = modelMem[aAddr]; vA = 1'b1; end
                if (bEn) begin rdB = modelMem[bAddr]; vB = 1'b1; end
                if (bEn) begin
                    word = modelMem[bAddr];
                    for (int i = 0; i < NL; i++) if (bWe[i]) word[i*LW +: LW] = bDin[i*LW +: LW];
                    modelMem[bAddr] = word;
                end
                if (aEn) begin
                    word = modelMem[aAddr];
                    for (int i = 0; i < NL; i++) if (aWe[i]) word[i*LW +: LW] = aDin[i*LW +: LW];
                    modelMem[aAddr] = word;
                end
                if (clrReq) clearLeft = DEPTH;
            end
            if (pipeVldA[0]) pipeDoutA[1] = pipeDoutA[0];
            if (pipeVldB[0]) pipeDoutB[1] = pipeDoutB[0];
            pipeVldA[1] = pipeVldA[0];
            pipeVldB[1] = pipeVldB[0];
            pipeDoutA[0] = rdA; pipeVldA[0] = vA;
            pipeDoutB[0] = rdB; pipeVldB[0] = vB;
        end
        #1;
        checkOutput("busy", 32'(busy), 32'(clearLeft > 0));
        checkOutput("a_vld", 32'(aVld), 32'(pipeVldA[LAT-1]));
        checkOutput("b_vld", 32'(bVld), 32'(pipeVldB[LAT-1]));
        checkOutput("a_dout", 32'(aDout), 32'(pipeDoutA[LAT-1]));
        checkOutput("b_dout", 32'(bDout), 32'(pipeDoutB[LAT-1]));
    end

    // Called at a falling edge; holds the inputs across one rising edge, then idles them
    task automatic applyStimulus(input logic ae, input logic [NL-1:0] awe, input logic [AW-1:0] aa,
                                 input logic [DW-1:0] ad, input logic be, input logic [NL-1:0] bwe,
                                 input logic [AW-1:0] ba, input logic [DW-1:0] bd, input logic clr);
        aEn = ae; aWe = awe; aAddr = aa; aDin = ad;
        bEn = be; bWe = bwe; bAddr = ba; bDin = bd; clrReq = clr;
        @(negedge clk);
        aEn = 1'b0; aWe = '0; bEn = 1'b0; bWe = '0; clrReq = 1'b0;
    endtask

    task automatic readCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expected, input string name);
        applyStimulus(1'b1, '0, addr, '0, 1'b1, '0, addr, '0, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        checkOutput({name, "_avld"}, 32'(aVld), 32'd1);
        checkOutput({name, "_adout"}, 32'(aDout), 32'(expected));
        checkOutput({name, "_bvld"}, 32'(bVld), 32'd1);
        checkOutput({name, "_bdout"}, 32'(bDout), 32'(expected));
    endtask

    // Counts falling edges until busy drops; optionally hammers both ports with writes meanwhile
    task automatic waitClear(input logic attemptWrites, output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            if (attemptWrites) begin
                aEn = 1'b1; aWe = '1; aAddr = AW'(cycles); aDin = 8'hFF;
                bEn = 1'b1; bWe = '1; bAddr = AW'(cycles + 5); bDin = 8'hEE;
            end
            @(negedge clk);
            cycles++;
        end
        aEn = 1'b0; aWe = '0; bEn = 1'b0; bWe = '0;
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0; clrReq = 1'b0;
        aEn = 1'b0; aWe = '0; aAddr = '0; aDin = '0;
        bEn = 1'b0; bWe = '0; bAddr = '0; bDin = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_avld", 32'(aVld), 32'd0);
        checkOutput("reset_adout", 32'(aDout), 32'd0);
        checkOutput("reset_bdout", 32'(bDout), 32'd0);

        rst_n = 1'b1;
        waitClear(1'b0, cycles);
        checkOutput("init_clear_cycles", 32'(cycles), 32'd16);
        for (int i = 0; i < DEPTH; i++) readCheck(AW'(i), 8'h00, "init_zero");

        applyStimulus(1'b1, 4'b1111, 4'd3, 8'hA5, 1'b0, '0, '0, '0, 1'b0);
        readCheck(4'd3, 8'hA5, "full_write");
        applyStimulus(1'b1, 4'b0010, 4'd3, 8'h0C, 1'b0, '0, '0, '0, 1'b0);
        readCheck(4'd3, 8'hAD, "lane_write");
        checkOutput("model_addr3", 32'(modelMem[3]), 32'hAD);

        applyStimulus(1'b1, 4'b0011, 4'd5, 8'hFF, 1'b1, 4'b1111, 4'd5, 8'h00, 1'b0);
        readCheck(4'd5, 8'h0F, "collision");
        checkOutput("model_addr5", 32'(modelMem[5]), 32'h0F);

        applyStimulus(1'b1, 4'b1111, 4'd7, 8'h11, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'd7, 8'h22, 1'b1, 4'b0000, 4'd7, 8'h00, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        checkOutput("rdw_bvld", 32'(bVld), 32'd1);
        checkOutput("rdw_bdout", 32'(bDout), 32'h11);
        readCheck(4'd7, 8'h22, "rdw_after");

        applyStimulus(1'b1, 4'b1111, 4'd2, 8'h5A, 1'b0, 4'b1111, 4'd2, 8'hC3, 1'b0);
        readCheck(4'd2, 8'h5A, "en_off_b");

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus(1'($urandom), NL'($urandom), ra, DW'($urandom),
                          1'($urandom), NL'($urandom),
                          ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1)),
                          DW'($urandom), ($urandom_range(0, 59) == 0));
        end

        waitClear(1'b0, cycles);
        checkOutput("idle_before_clear", 32'(busy), 32'd0);
        applyStimulus(1'b1, 4'b1111, 4'd9, 8'h99, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 4'b1111, 4'd12, 8'h77, 1'b1, 4'b1111, 4'd13, 8'h66, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midclear_rst_busy", 32'(busy), 32'd1);
        checkOutput("midclear_rst_bvld", 32'(bVld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitClear(1'b1, cycles);
        checkOutput("restart_clear_cycles", 32'(cycles), 32'd16);
        for (int i = 0; i < DEPTH; i++) readCheck(AW'(i), 8'h00, "final_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/memdp_clr.md
MEMDP_CLR -- requirements
Module: memdp_clr

Interface
REQ-001 Parameter LW, default 2, width in bits of one write lane.
REQ-002 Parameter NL, default 4, number of write lanes; data width DW = LW*NL (default 8).
REQ-003 Parameter AW, default 4, address width; depth = 2**AW words (default 16).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 clr_req  input  1  request a full-memory clear sequence.
REQ-007 busy  output  1  high while the clear sequence runs.
REQ-008 a_en  input  1  port A access enable.
REQ-009 a_we  input  NL  port A per-lane write enables.
REQ-010 a_addr  input  AW  port A address.
REQ-011 a_din  input  DW  port A write data.
REQ-012 a_dout  output  DW  port A registered read data.
REQ-013 a_vld  output  1  port A read-data-valid strobe.
REQ-014 b_en, b_we, b_addr, b_din, b_dout, b_vld  same directions, widths and meanings as port A, for port B.

Function
REQ-015 FSM states: CLEAR and IDLE; counter clr_cnt is AW bits wide.
REQ-016 In CLEAR: write all-zero to word clr_cnt each cycle and increment clr_cnt; after the write to 2**AW-1, go to IDLE (2**AW cycles total).
REQ-017 In IDLE: if clr_req=1, next state is CLEAR with clr_cnt=0; otherwise stay in IDLE.
REQ-018 clr_req while in CLEAR: ignored; the running sequence neither restarts nor extends.
REQ-019 busy = 1 exactly when the FSM is in CLEAR.
REQ-020 While busy: port writes are dropped, reads are not performed, and a_vld=b_vld=0.
REQ-021 Access in IDLE with en=1: for each lane i with we[i]=1, write din[i*LW +: LW] to mem[addr][i*LW +: LW]; lanes with we[i]=0 are unchanged.
REQ-022 Read: every access with en=1 is also a read; dout is mem[addr] in the cycle after the access, vld=1 for that one cycle (latency 1).
REQ-023 Read-during-write, same port or cross port, returns old data (read-first).
REQ-024 dout holds its last value whenever vld=0.
REQ-025 Both ports write the same address in the same cycle: per lane, port A wins where a_we[i]=1; port B writes only lanes where a_we[i]=0 and b_we[i]=1.
REQ-026 en=0: no read or write on that port, regardless of we.

Reset
REQ-027 rst_n=0 immediately forces: FSM=CLEAR, clr_cnt=0, a_dout=b_dout=0, a_vld=b_vld=0, busy=1.
REQ-028 The memory array has no direct reset; its contents are zeroed by the CLEAR sequence that starts when rst_n deasserts.
REQ-029 rst_n asserted mid-clear or mid-access: any in-flight read is discarded and the clear restarts from address 0.

Configuration
REQ-030 Macro MEMDP_OUTREG_EN, when defined, adds one output register stage per port.
REQ-031 With MEMDP_OUTREG_EN defined: read latency is 2, vld is delayed with the data, and the extra registers also reset to 0.
REQ-032 Without MEMDP_OUTREG_EN: read latency is 1 as in REQ-022.

Verification
REQ-033 Release rst_n -> busy=1 for exactly 16 cycles; then reading every address 0..15 returns 8'h00.
REQ-034 A: write addr 3, we=4'b1111, din=8'hA5; next cycle read addr 3 -> a_dout=8'hA5 with a_vld=1 one cycle later.
REQ-035 Addr 3 holds 8'hA5; A writes addr 3 with we=4'b0010, din=8'h0C -> readback 8'hAD.
REQ-036 Same cycle, addr 5: A we=4'b0011 din=8'hFF, B we=4'b1111 din=8'h00 -> readback 8'h0F.
REQ-037 Addr 7 holds 8'h11; same cycle A writes 8'h22 to addr 7 and B reads addr 7 -> b_dout=8'h11; a later read returns 8'h22.
REQ-038 Assert clr_req in IDLE, pulse clr_req again 4 cycles later, and assert rst_n=0 for 1 cycle at clear cycle 8 -> busy drops 16 cycles after rst_n release, all words read 0, and writes attempted while busy are not stored.
